control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 1, number of cycles each memory access (read or write) is held, range 1..15.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port ir  input  32  instruction register value from the datapath: opcode[31:27], Ra[26:23], Rb[22:19], Rc[18:15].
REQ-005 SHALL have port con_ff  input  1  branch-condition flag from the datapath.
REQ-006 SHALL have port stop  input  1  request to halt at the next instruction boundary.
REQ-007 SHALL have port reg_in  output  16  one-hot R0in..R15in strobes.
REQ-008 SHALL have port reg_out  output  16  one-hot R0out..R15out strobes.
REQ-009 SHALL have port misc_in  output  9  {CONin,LOin,HIin,Zin,Yin,IRin,MDRin,MARin,PCin}, bit 0 = PCin.
REQ-010 SHALL have port misc_out  output  7  {Cout,LOout,HIout,Zhighout,Zlowout,MDRout,PCout}, bit 0 = PCout.
REQ-011 SHALL have ports inc_pc, read, write  output  1 each  datapath ALU increment and memory strobes.
REQ-012 SHALL have port alu_op  output  4  ALU control code; port run  output  1  high while executing.

Function
REQ-013 SHALL be a state machine with states RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT; outputs SHALL depend only on state, ir and a wait counter, except pc_in at T6, which also depends on con_ff.
REQ-014 SHALL, in at most one cycle, assert at most one bit of reg_out|misc_out combined (single bus driver).
REQ-015 SHALL fetch as: T0 PCout,MARin,inc_pc,Zin; T1 Zlowout,PCin,read,MDRin; T2 MDRout,IRin.
REQ-016 SHALL, in any state containing read or write, hold that strobe MEM_WAIT cycles via a down-counter; MDRin/PCin asserted only in the final cycle of that state.
REQ-017 SHALL execute add(00011)/sub(00100)/and(00101)/or(00110) as: T3 Rb out,Yin; T4 Rc out,alu_op,Zin; T5 Zlowout,Ra in; then T0.
REQ-018 SHALL execute addi(01100)/andi(01101)/ori(01110)/ldi(00001) as: T3 Rb out,Yin; T4 Cout,alu_op,Zin; T5 Zlowout,Ra in (ldi uses ADD).
REQ-019 SHALL execute ld(00000) as: T3 Rb out,Yin; T4 Cout,ADD,Zin; T5 Zlowout,MARin; T6 read,MDRin; T7 MDRout,Ra in.
REQ-020 SHALL execute st(00010) as: T3-T5 as ld; T6 Ra out,MDRin with read=0; T7 write.
REQ-021 SHALL execute br(10010) as: T3 Ra out,CONin; T4 PCout,Yin; T5 Cout,ADD,Zin; T6 Zlowout, and PCin only if con_ff=1.
REQ-022 SHALL treat nop(11000) and any undefined opcode as T2 -> T0 with no execute strobes.
REQ-023 SHALL enter HALT after T2 for halt(11001), and at T0 entry when stop=1 sampled at an instruction's last state; HALT is left only by reset.
REQ-024 SHALL drive run=1 in T0..T7 and run=0 in RST and HALT.

Reset
REQ-025 SHALL, on reset=0, immediately force state RST, wait counter 0, and all outputs 0, independent of clk.
REQ-026 SHALL leave RST for T0 on the first rising clk edge after reset returns to 1; reset mid-instruction aborts it with no further strobes.

Configuration
REQ-027 SHALL, when CTRL_MULDIV_EN is defined, execute mul(01111)/div(10000) as: T3 Ra out,Yin; T4 Rb out,alu_op,Zin; T5 Zlowout,LOin; T6 Zhighout,HIin.
REQ-028 SHALL, when CTRL_MULDIV_EN is undefined, treat mul/div as nop per REQ-022.

Structure
REQ-029 SHALL place the state enumeration, opcode constants, alu_op codes (ADD=0011, SUB=0100, AND=0101, OR=0110, MUL=0111, DIV=1000) and misc bit indices in shared package ctrl_pkg.
REQ-030 SHALL use one sub-module, ctrl_decoder, mapping ir to instruction class and one-hot Ra/Rb/Rc select vectors.

Verification
REQ-031 SHALL verify: reset low mid-T4, then released -> all outputs 0 immediately; T0 on next edge; run=1.
REQ-032 SHALL verify: ir=add R1,R2,R3 (0x18918000) -> reg_out=0x0004 at T3, 0x0008 with alu_op=0011 at T4, reg_in=0x0002 at T5.
REQ-033 SHALL verify: MEM_WAIT=3, ld -> read high 3 cycles in T1 and T6; MDRin only in the third of each.
REQ-034 SHALL verify: br with con_ff=0 -> no PCin at T6; with con_ff=1 -> misc_in[0]=1 at T6.
REQ-035 SHALL verify: stop=1 during T5 of add -> HALT after T5, run=0, no T0 strobes; halt opcode -> HALT after T2.
REQ-036 SHALL verify: mul opcode with and without CTRL_MULDIV_EN -> LOin/HIin at T5/T6 versus return to T0 after T2.

Source files
------------

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared definitions for the hardwired control unit: FSM state
//                encoding, instruction classes, opcodes, ALU codes and the
//                bit positions inside the misc_in / misc_out strobe vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // Control step sequence; RST and HALT are the only non-running states.
    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } state_e;

    // Instruction classes sharing one execute-step pattern.
    typedef enum logic [2:0] {
        CL_NOP    = 3'd0,
        CL_ALU    = 3'd1,
        CL_IMM    = 3'd2,
        CL_LD     = 3'd3,
        CL_ST     = 3'd4,
        CL_BR     = 3'd5,
        CL_MULDIV = 3'd6,
        CL_HALT   = 3'd7
    } iclass_e;

    // Opcodes, ir[31:27]
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11001;

    // ALU control codes
    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_MUL  = 4'b0111;
    localparam logic [3:0] ALU_DIV  = 4'b1000;

    // misc_in bit positions
    localparam int MI_PC  = 0;
    localparam int MI_MAR = 1;
    localparam int MI_MDR = 2;
    localparam int MI_IR  = 3;
    localparam int MI_Y   = 4;
    localparam int MI_Z   = 5;
    localparam int MI_HI  = 6;
    localparam int MI_LO  = 7;
    localparam int MI_CON = 8;

    // misc_out bit positions
    localparam int MO_PC  = 0;
    localparam int MO_MDR = 1;
    localparam int MO_ZLO = 2;
    localparam int MO_ZHI = 3;
    localparam int MO_HI  = 4;
    localparam int MO_LO  = 5;
    localparam int MO_C   = 6;

    // Register-file select: 4-bit index to a one-hot strobe vector.
    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_decoder
//  Description : Maps the instruction register to an instruction class, the
//                ALU code used by its execute steps, and one-hot Ra/Rb/Rc
//                register selects.
//                Macro CTRL_MULDIV_EN: when defined, mul/div decode to the
//                MULDIV class; otherwise they decode as nop.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [31:0] ir_i,
    output iclass_e     iclass_o,
    output logic [3:0]  alu_sel_o,
    output logic [15:0] ra_sel_o,
    output logic [15:0] rb_sel_o,
    output logic [15:0] rc_sel_o
);

    logic [4:0] opcode;
    logic       unused_ir_low;

    assign opcode        = ir_i[31:27];
    assign ra_sel_o      = onehot16(ir_i[26:23]);
    assign rb_sel_o      = onehot16(ir_i[22:19]);
    assign rc_sel_o      = onehot16(ir_i[18:15]);
    // Immediate/constant field is consumed by the datapath, not here.
    assign unused_ir_low = ^ir_i[14:0];

    // Opcode to class and ALU code; anything unlisted behaves as nop.
    always_comb begin
        iclass_o  = CL_NOP;
        alu_sel_o = ALU_NONE;
        case (opcode)
            OP_ADD:  begin iclass_o = CL_ALU;  alu_sel_o = ALU_ADD; end
            OP_SUB:  begin iclass_o = CL_ALU;  alu_sel_o = ALU_SUB; end
            OP_AND:  begin iclass_o = CL_ALU;  alu_sel_o = ALU_AND; end
            OP_OR:   begin iclass_o = CL_ALU;  alu_sel_o = ALU_OR;  end
            OP_ADDI: begin iclass_o = CL_IMM;  alu_sel_o = ALU_ADD; end
            OP_ANDI: begin iclass_o = CL_IMM;  alu_sel_o = ALU_AND; end
            OP_ORI:  begin iclass_o = CL_IMM;  alu_sel_o = ALU_OR;  end
            OP_LDI:  begin iclass_o = CL_IMM;  alu_sel_o = ALU_ADD; end
            OP_LD:   begin iclass_o = CL_LD;   alu_sel_o = ALU_ADD; end
            OP_ST:   begin iclass_o = CL_ST;   alu_sel_o = ALU_ADD; end
            OP_BR:   begin iclass_o = CL_BR;   alu_sel_o = ALU_ADD; end
            OP_HALT: begin iclass_o = CL_HALT; end
`ifdef CTRL_MULDIV_EN
            OP_MUL:  begin iclass_o = CL_MULDIV; alu_sel_o = ALU_MUL; end
            OP_DIV:  begin iclass_o = CL_MULDIV; alu_sel_o = ALU_DIV; end
`endif
            default: begin iclass_o = CL_NOP; alu_sel_o = ALU_NONE; end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit
//  Description : Hardwired control unit: fetch (T0-T2) and per-class execute
//                steps (T3-T7). Memory steps hold read/write for MEM_WAIT
//                cycles; MDRin/PCin fire only in the last of those cycles.
//                Macro CTRL_MULDIV_EN: enables mul/div execute sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_unit
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        stop,
    output logic [15:0] reg_in,
    output logic [15:0] reg_out,
    output logic [8:0]  misc_in,
    output logic [6:0]  misc_out,
    output logic        inc_pc,
    output logic        read,
    output logic        write,
    output logic [3:0]  alu_op,
    output logic        run
);

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        instr_done;
    logic        hold;
    logic        last_cycle;

    iclass_e     iclass;
    logic [3:0]  alu_sel;
    logic [15:0] ra_sel, rb_sel, rc_sel;

    ctrl_decoder u_dec (
        .ir_i      (ir),
        .iclass_o  (iclass),
        .alu_sel_o (alu_sel),
        .ra_sel_o  (ra_sel),
        .rb_sel_o  (rb_sel),
        .rc_sel_o  (rc_sel)
    );

    // States that carry a read or write strobe and therefore wait on memory.
    function automatic logic is_mem_state(input state_e s, input iclass_e c);
        return (s == S_T1) || (s == S_T6 && c == CL_LD) || (s == S_T7 && c == CL_ST);
    endfunction

    assign hold       = is_mem_state(state_q, iclass) && (cnt_q != 4'd0);
    assign last_cycle = (cnt_q == 4'd0);

    // State and wait-counter registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RST;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: stay while memory is busy, else step through the class sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        instr_done = 1'b0;
        if (hold) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            case (state_q)
                S_RST:  state_d = S_T0;
                S_T0:   state_d = S_T1;
                S_T1:   state_d = S_T2;
                S_T2: begin
                    if (iclass == CL_NOP)       instr_done = 1'b1;
                    else if (iclass == CL_HALT) state_d = S_HALT;
                    else                        state_d = S_T3;
                end
                S_T3:   state_d = S_T4;
                S_T4:   state_d = S_T5;
                S_T5: begin
                    if (iclass == CL_ALU || iclass == CL_IMM) instr_done = 1'b1;
                    else                                      state_d = S_T6;
                end
                S_T6: begin
                    if (iclass == CL_LD || iclass == CL_ST) state_d = S_T7;
                    else                                    instr_done = 1'b1;
                end
                S_T7:   instr_done = 1'b1;
                S_HALT: state_d = S_HALT;
                default: state_d = S_RST;
            endcase
            // A stop request seen at an instruction boundary replaces the next fetch.
            if (instr_done) state_d = stop ? S_HALT : S_T0;
            cnt_d = is_mem_state(state_d, iclass) ? WAIT_LOAD : 4'd0;
        end
    end

    // Control strobes decoded from state, instruction class and wait counter.
    always_comb begin
        reg_in   = 16'h0000;
        reg_out  = 16'h0000;
        misc_in  = 9'h000;
        misc_out = 7'h00;
        inc_pc   = 1'b0;
        read     = 1'b0;
        write    = 1'b0;
        alu_op   = ALU_NONE;
        run      = (state_q != S_RST) && (state_q != S_HALT);
        case (state_q)
            S_T0: begin
                misc_out[MO_PC] = 1'b1;
                misc_in[MI_MAR] = 1'b1;
                misc_in[MI_Z]   = 1'b1;
                inc_pc          = 1'b1;
            end
            S_T1: begin
                misc_out[MO_ZLO] = 1'b1;
                read             = 1'b1;
                misc_in[MI_PC]   = last_cycle;
                misc_in[MI_MDR]  = last_cycle;
            end
            S_T2: begin
                misc_out[MO_MDR] = 1'b1;
                misc_in[MI_IR]   = 1'b1;
            end
            S_T3: begin
                case (iclass)
                    CL_BR:     begin reg_out = ra_sel; misc_in[MI_CON] = 1'b1; end
                    CL_MULDIV: begin reg_out = ra_sel; misc_in[MI_Y]   = 1'b1; end
                    CL_ALU, CL_IMM, CL_LD, CL_ST:
                               begin reg_out = rb_sel; misc_in[MI_Y]   = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (iclass)
                    CL_ALU:    begin reg_out = rc_sel; alu_op = alu_sel; misc_in[MI_Z] = 1'b1; end
                    CL_MULDIV: begin reg_out = rb_sel; alu_op = alu_sel; misc_in[MI_Z] = 1'b1; end
                    CL_IMM, CL_LD, CL_ST:
                               begin misc_out[MO_C] = 1'b1; alu_op = alu_sel; misc_in[MI_Z] = 1'b1; end
                    CL_BR:     begin misc_out[MO_PC] = 1'b1; misc_in[MI_Y] = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (iclass)
                    CL_ALU, CL_IMM: begin misc_out[MO_ZLO] = 1'b1; reg_in = ra_sel; end
                    CL_LD, CL_ST:   begin misc_out[MO_ZLO] = 1'b1; misc_in[MI_MAR] = 1'b1; end
                    CL_BR:          begin misc_out[MO_C] = 1'b1; alu_op = alu_sel; misc_in[MI_Z] = 1'b1; end
                    CL_MULDIV:      begin misc_out[MO_ZLO] = 1'b1; misc_in[MI_LO] = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (iclass)
                    CL_LD:     begin read = 1'b1; misc_in[MI_MDR] = last_cycle; end
                    CL_ST:     begin reg_out = ra_sel; misc_in[MI_MDR] = 1'b1; end
                    CL_BR:     begin misc_out[MO_ZLO] = 1'b1; misc_in[MI_PC] = con_ff; end
                    CL_MULDIV: begin misc_out[MO_ZHI] = 1'b1; misc_in[MI_HI] = 1'b1; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (iclass)
                    CL_LD:   begin misc_out[MO_MDR] = 1'b1; reg_in = ra_sel; end
                    CL_ST:   write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_unit
//  Description : Self-checking bench for control_unit. A step-list model
//                builds the expected strobe vector for every clock of each
//                instruction; a compare process checks the DUT every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;

    localparam int MW = 3;

    // misc_in / misc_out bit meanings
    localparam int PCIN = 0, MARIN = 1, MDRIN = 2, IRIN = 3, YIN = 4, ZIN = 5,
                   HIIN = 6, LOIN = 7, CONIN = 8;
    localparam int PCOUT = 0, MDROUT = 1, ZLOOUT = 2, ZHIOUT = 3, COUT = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ir = 32'h0;
    logic        con_ff = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] reg_in, reg_out;
    logic [8:0]  misc_in;
    logic [6:0]  misc_out;
    logic        inc_pc, read, write, run;
    logic [3:0]  alu_op;

    control_unit #(.MEM_WAIT(MW)) dut (
        .clk      (clk),
        .reset    (reset),
        .ir       (ir),
        .con_ff   (con_ff),
        .stop     (stop),
        .reg_in   (reg_in),
        .reg_out  (reg_out),
        .misc_in  (misc_in),
        .misc_out (misc_out),
        .inc_pc   (inc_pc),
        .read     (read),
        .write    (write),
        .alu_op   (alu_op),
        .run      (run)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic [8:0]  min;
        logic [6:0]  mout;
        logic        inc;
        logic        rd;
        logic        wr;
        logic [3:0]  alu;
        logic        run;
    } obs_t;

    typedef struct {
        obs_t  v;
        string tag;
    } step_t;

    obs_t  obs_now;
    step_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    assign obs_now = {reg_in, reg_out, misc_in, misc_out, inc_pc, read, write, alu_op, run};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic obs_t active();
        obs_t s;
        s     = '0;
        s.run = 1'b1;
        return s;
    endfunction

    task automatic push(input obs_t v, input string tag);
        step_t e;
        e.v   = v;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c);
        return {op, a, b, c, 15'h0};
    endfunction

    // Expected per-cycle strobes for one instruction (plus HALT cycles if it stops).
    task automatic model_instr(input logic [31:0] i, input logic c, input logic stp, output int n);
        obs_t        s;
        logic [4:0]  op;
        logic [15:0] ra, rb, rc;
        logic [3:0]  alu;
        int          kind;   // 0 none,1 reg-reg,2 imm,3 ld,4 st,5 br,6 mul/div,7 halt
        int          start;
        start = exp_q.size();
        op = i[31:27];
        ra = 16'h0001 << i[26:23];
        rb = 16'h0001 << i[22:19];
        rc = 16'h0001 << i[18:15];
        kind = 0;
        alu  = 4'd0;
        case (op)
            5'b00011: begin kind = 1; alu = 4'b0011; end
            5'b00100: begin kind = 1; alu = 4'b0100; end
            5'b00101: begin kind = 1; alu = 4'b0101; end
            5'b00110: begin kind = 1; alu = 4'b0110; end
            5'b01100: begin kind = 2; alu = 4'b0011; end
            5'b01101: begin kind = 2; alu = 4'b0101; end
            5'b01110: begin kind = 2; alu = 4'b0110; end
            5'b00001: begin kind = 2; alu = 4'b0011; end
            5'b00000: begin kind = 3; alu = 4'b0011; end
            5'b00010: begin kind = 4; alu = 4'b0011; end
            5'b10010: begin kind = 5; alu = 4'b0011; end
            5'b11001: kind = 7;
`ifdef CTRL_MULDIV_EN
            5'b01111: begin kind = 6; alu = 4'b0111; end
            5'b10000: begin kind = 6; alu = 4'b1000; end
`endif
            default: kind = 0;
        endcase

        s = active(); s.mout[PCOUT] = 1; s.min[MARIN] = 1; s.min[ZIN] = 1; s.inc = 1; push(s, "T0");
        for (int k = 0; k < MW; k++) begin
            s = active(); s.mout[ZLOOUT] = 1; s.rd = 1;
            if (k == MW - 1) begin s.min[PCIN] = 1; s.min[MDRIN] = 1; end
            push(s, "T1");
        end
        s = active(); s.mout[MDROUT] = 1; s.min[IRIN] = 1; push(s, "T2");

        if (kind >= 1 && kind <= 6) begin
            // T3
            s = active();
            if (kind == 5)      begin s.rout = ra; s.min[CONIN] = 1; end
            else if (kind == 6) begin s.rout = ra; s.min[YIN] = 1; end
            else                begin s.rout = rb; s.min[YIN] = 1; end
            push(s, "T3");
            // T4
            s = active();
            if (kind == 1)      begin s.rout = rc; s.alu = alu; s.min[ZIN] = 1; end
            else if (kind == 6) begin s.rout = rb; s.alu = alu; s.min[ZIN] = 1; end
            else if (kind == 5) begin s.mout[PCOUT] = 1; s.min[YIN] = 1; end
            else                begin s.mout[COUT] = 1; s.alu = alu; s.min[ZIN] = 1; end
            push(s, "T4");
            // T5
            s = active();
            if (kind <= 2)      begin s.mout[ZLOOUT] = 1; s.rin = ra; end
            else if (kind <= 4) begin s.mout[ZLOOUT] = 1; s.min[MARIN] = 1; end
            else if (kind == 5) begin s.mout[COUT] = 1; s.alu = alu; s.min[ZIN] = 1; end
            else                begin s.mout[ZLOOUT] = 1; s.min[LOIN] = 1; end
            push(s, "T5");
        end
        if (kind == 3) begin
            for (int k = 0; k < MW; k++) begin
                s = active(); s.rd = 1; s.min[MDRIN] = (k == MW - 1); push(s, "T6");
            end
            s = active(); s.mout[MDROUT] = 1; s.rin = ra; push(s, "T7");
        end else if (kind == 4) begin
            s = active(); s.rout = ra; s.min[MDRIN] = 1; push(s, "T6");
            for (int k = 0; k < MW; k++) begin
                s = active(); s.wr = 1; push(s, "T7");
            end
        end else if (kind == 5) begin
            s = active(); s.mout[ZLOOUT] = 1; s.min[PCIN] = c; push(s, "T6");
        end else if (kind == 6) begin
            s = active(); s.mout[ZHIOUT] = 1; s.min[HIIN] = 1; push(s, "T6");
        end
        if (stp || kind == 7) begin
            for (int k = 0; k < 3; k++) push('0, "HALT");
        end
        n = exp_q.size() - start;
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        step_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, 64'(obs_now), 64'(e.v));
        end
    end

    // Assert reset at posedge+2, check outputs drop at once, release one cycle later.
    task automatic apply_reset(input string name);
        exp_q.delete();
        reset = 1'b0;
        #1;
        check(name, 64'(obs_now), 64'h0);
        push('0, "RST_hold");
        @(posedge clk); #2;
        reset = 1'b1;
        push('0, "RST");
        @(posedge clk); #2;
    endtask

    task automatic run_instr(input logic [31:0] i, input logic c, input logic stp);
        int n;
        ir     = i;
        con_ff = c;
        stop   = stp;
        model_instr(i, c, stp, n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int n, cnt_rd, cnt_mdr;
        logic [31:0] prog_ir [0:16];
        logic        prog_c  [0:16];

        // Hand-computed expectations pinning the model itself
        model_instr(32'h18918000, 1'b0, 1'b0, n);
        check("pin_add_len", 64'(n), 64'(MW + 5));
        check("pin_add_T3_rout", 64'(exp_q[MW + 2].v.rout), 64'h0004);
        check("pin_add_T4_rout", 64'(exp_q[MW + 3].v.rout), 64'h0008);
        check("pin_add_T4_alu",  64'(exp_q[MW + 3].v.alu),  64'h3);
        check("pin_add_T5_rin",  64'(exp_q[MW + 4].v.rin),  64'h0002);
        exp_q.delete();
        model_instr(enc(5'b00000, 4'd6, 4'd1, 4'd0), 1'b0, 1'b0, n);
        cnt_rd = 0; cnt_mdr = 0;
        foreach (exp_q[k]) begin
            if (exp_q[k].v.rd) cnt_rd++;
            if (exp_q[k].v.min[MDRIN]) cnt_mdr++;
        end
        check("pin_ld_reads", 64'(cnt_rd), 64'(2 * MW));
        check("pin_ld_mdrin", 64'(cnt_mdr), 64'd2);
        exp_q.delete();
        model_instr(enc(5'b10010, 4'd3, 4'd0, 4'd0), 1'b1, 1'b0, n);
        check("pin_br1_T6_min", 64'(exp_q[n - 1].v.min), 64'h001);
        exp_q.delete();

        prog_ir[0]  = 32'h18918000;                       prog_c[0]  = 0;
        prog_ir[1]  = enc(5'b00100, 4'd4, 4'd5, 4'd6);    prog_c[1]  = 0;
        prog_ir[2]  = enc(5'b00101, 4'd7, 4'd8, 4'd9);    prog_c[2]  = 0;
        prog_ir[3]  = enc(5'b00110, 4'd15, 4'd0, 4'd14);  prog_c[3]  = 0;
        prog_ir[4]  = enc(5'b01100, 4'd2, 4'd3, 4'd0);    prog_c[4]  = 0;
        prog_ir[5]  = enc(5'b01101, 4'd10, 4'd11, 4'd0);  prog_c[5]  = 0;
        prog_ir[6]  = enc(5'b01110, 4'd12, 4'd13, 4'd0);  prog_c[6]  = 0;
        prog_ir[7]  = enc(5'b00001, 4'd5, 4'd0, 4'd0);    prog_c[7]  = 0;
        prog_ir[8]  = enc(5'b00000, 4'd6, 4'd1, 4'd0);    prog_c[8]  = 0;
        prog_ir[9]  = enc(5'b00010, 4'd7, 4'd2, 4'd0);    prog_c[9]  = 0;
        prog_ir[10] = enc(5'b10010, 4'd3, 4'd0, 4'd0);    prog_c[10] = 0;
        prog_ir[11] = enc(5'b10010, 4'd3, 4'd0, 4'd0);    prog_c[11] = 1;
        prog_ir[12] = enc(5'b11000, 4'd0, 4'd0, 4'd0);    prog_c[12] = 0;
        prog_ir[13] = enc(5'b10101, 4'd1, 4'd2, 4'd3);    prog_c[13] = 0;
        prog_ir[14] = enc(5'b01111, 4'd1, 4'd2, 4'd0);    prog_c[14] = 0;
        prog_ir[15] = enc(5'b10000, 4'd3, 4'd4, 4'd0);    prog_c[15] = 1;
        prog_ir[16] = enc(5'b01100, 4'd9, 4'd9, 4'd0);    prog_c[16] = 0;

        @(posedge clk); #2;
        apply_reset("reset_initial");
        for (int k = 0; k < 17; k++) run_instr(prog_ir[k], prog_c[k], 1'b0);

        // stop during an add: HALT instead of the next fetch
        run_instr(32'h18918000, 1'b0, 1'b1);
        stop = 1'b0;
        apply_reset("reset_in_halt");

        // abort an add in T4
        ir = 32'h18918000;
        model_instr(32'h18918000, 1'b0, 1'b0, n);
        repeat (3 + MW) @(posedge clk);
        #2;
        apply_reset("reset_mid_T4");

        // halt opcode stops after T2
        run_instr(enc(5'b11001, 4'd0, 4'd0, 4'd0), 1'b0, 1'b0);
        apply_reset("reset_after_halt");
        run_instr(enc(5'b00010, 4'd1, 4'd2, 4'd0), 1'b0, 1'b1);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
